atd_rx_controller: RTL and testbench
====================================

# atd_rx_controller

Sequences one serial sample capture from the external ATD converter. It asserts chip select, then counts shift strobes from the ATD edge detector and assembles `WORD_BITS` MSB-first data bits. It presents the finished word on a valid/ready output port and aborts on a stalled converter clock. It sits between the ATD edge detector and the sample consumer in the receive path.

## Interface
- `WORD_BITS`, 12: bits per sample; legal range 2..32.
- `TIMEOUT_CYCLES`, 1023: consecutive SHIFT-state `clk` cycles without a strobe before the frame is aborted; legal range ≥2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request one conversion; sampled only in IDLE.
- `ATD_shift_enable`  in  1  one-cycle strobe per ATD_clk rising edge, from the edge detector.
- `ATD_data`  in  1  serial data, already synchronized to `clk`.
- `ATD_cs_n`  out  1  converter chip select, active low.
- `busy`  out  1  high in every state except IDLE.
- `sample_data`  out  WORD_BITS  last completed sample.
- `sample_valid`  out  1  `sample_data` holds an unconsumed sample.
- `sample_ready`  in  1  consumer accepts the sample at any edge where `sample_valid & sample_ready`.
- `timeout_err`  out  1  sticky; the last frame aborted.
- `overrun`  out  1  sticky; an unconsumed sample was overwritten.

## Operation
- Reset values: state IDLE, `ATD_cs_n`=1, `busy`=0, `sample_data`=0, `sample_valid`=0, `timeout_err`=0, `overrun`=0, bit count 0, timeout count 0.
- IDLE: `start`=1 → SELECT. At that edge, clear `timeout_err` and `overrun` and zero the shift register. Strobes in IDLE are ignored.
- SELECT: lasts exactly one cycle; `ATD_cs_n`=0; strobes are ignored. Next state is SHIFT, with bit count and timeout count cleared.
- SHIFT: `ATD_cs_n`=0. On a strobe, shift `ATD_data` into the LSB (MSB-first word), increment bit count, and clear timeout count.
- Final bit: a strobe with bit count = `WORD_BITS`-1 completes the frame. At that edge:
  - load `sample_data` with the full word (including this bit);
  - set `sample_valid`=1;
  - go to DONE.
- Timeout: a non-strobe SHIFT cycle with timeout count = `TIMEOUT_CYCLES`-1 aborts the frame. At that edge:
  - go to IDLE and set `timeout_err`=1;
  - `ATD_cs_n` rises;
  - `sample_data` and `sample_valid` are untouched.
- DONE: one cycle with `ATD_cs_n`=0 (hold time), then → IDLE.
- Output handshake: `sample_valid` clears at an edge with `sample_valid & sample_ready`, unless a completion occurs at the same edge.
  - Completion and accept at the same edge: the new word loads, `sample_valid` stays 1, no overrun.
  - Completion while `sample_valid`=1 and `sample_ready`=0: the new word overwrites and `overrun`=1.
- `start` outside IDLE is ignored; requests are not queued.
- Bit counter width: $clog2(WORD_BITS). Timeout counter width: $clog2(TIMEOUT_CYCLES). Neither wraps; both are cleared as stated above.

## Timing
- `start` high in IDLE during cycle 0 gives:
  - `ATD_cs_n`=0 and `busy`=1 from cycle 1 (SELECT);
  - SHIFT from cycle 2; the first countable strobe is in cycle 2.
- Final strobe in cycle t gives:
  - `sample_valid`=1 and new `sample_data` in cycle t+1 (DONE);
  - `ATD_cs_n`=1 and `busy`=0 in cycle t+2.
  - Earliest next `start` acceptance is in cycle t+2.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Reset asserted mid-frame immediately forces all reset values, including `ATD_cs_n`=1 and dropping any pending sample, without waiting for a clock edge.

## Structure
- Shared package `atd_pkg`:
  - `atd_state_t` enum {IDLE, SELECT, SHIFT, DONE};
  - default constants `ATD_WORD_BITS`=12 and `ATD_TIMEOUT_CYCLES`=1023.
- One sub-module, `atd_timeout_timer`: clear/enable counter with a terminal-count output, parameterized by `TIMEOUT_CYCLES`. The FSM, bit counter, shift register and output register live in the top module.

## Test plan
- Use `WORD_BITS`=12 and `TIMEOUT_CYCLES`=16 unless noted.
- Basic frame: `start`, then 12 strobes four cycles apart carrying 0xA5C MSB-first → `sample_data`=12'hA5C, `sample_valid`=1 in the cycle after the 12th strobe, `ATD_cs_n`=1 two cycles after it, no error flags.
- Timeout: `start`, 3 strobes, then silence → `timeout_err`=1 and `ATD_cs_n`=1 after exactly 16 strobe-free SHIFT cycles; `sample_valid` stays 0. The next `start` clears `timeout_err`.
- Overrun and handshake:
  - Frame 0x123 with `sample_ready`=0, then frame 0xFFF → `sample_data`=12'hFFF and `overrun`=1.
  - Repeat with `sample_ready`=1 at the completion edge → no overrun.
- Ignored inputs: strobes in IDLE and SELECT are not counted, and `start` pulses during SHIFT/DONE are ignored. Check that a strobe in SELECT followed by 12 SHIFT strobes yields exactly the 12 SHIFT bits.
- Reset mid-frame: assert `rst` after 6 of 12 strobes → all outputs at reset values asynchronously. After release, a fresh frame 0x0F0 captures correctly.

Source files
------------

// File: rtl/atd_pkg.sv
// Shared types and default constants for the ATD receive controller.
package atd_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } atd_state_t;

  localparam int ATD_WORD_BITS      = 12;
  localparam int ATD_TIMEOUT_CYCLES = 1023;
endpackage

// File: rtl/atd_timeout_timer.sv
// Saturating clear/enable counter; terminal is high at count TIMEOUT_CYCLES-1.
module atd_timeout_timer
  import atd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ATD_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Holds at the terminal value instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);
endmodule

// File: rtl/atd_rx_controller.sv
// Sequences one serial ATD capture: chip select, MSB-first bit assembly,
// valid/ready output register and stalled-clock abort.
module atd_rx_controller
  import atd_pkg::*;
#(
  parameter int WORD_BITS      = ATD_WORD_BITS,
  parameter int TIMEOUT_CYCLES = ATD_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ATD_shift_enable,
  input  logic                 ATD_data,
  output logic                 ATD_cs_n,
  output logic                 busy,
  output logic [WORD_BITS-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 timeout_err,
  output logic                 overrun
);
  localparam int BW = $clog2(WORD_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

  atd_state_t           state;
  atd_state_t           state_next;
  logic [BW-1:0]        bit_count;
  logic [WORD_BITS-1:0] shift_reg;
  logic [WORD_BITS-1:0] word_next;
  logic                 accept_start;
  logic                 strobe;
  logic                 complete;
  logic                 abort;
  logic                 tmr_terminal;

  assign word_next = {shift_reg[WORD_BITS-2:0], ATD_data};

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    strobe       = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = SELECT;
        end
      end
      SELECT: state_next = SHIFT;
      SHIFT: begin
        strobe = ATD_shift_enable;
        if (strobe && (bit_count == LAST_BIT)) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if (!strobe && tmr_terminal) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  atd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == SELECT) || strobe),
    .enable  ((state == SHIFT) && !ATD_shift_enable),
    .terminal(tmr_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Completion takes priority over a same-edge accept so the new word stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count    <= '0;
      shift_reg    <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (accept_start) begin
        shift_reg   <= '0;
        timeout_err <= 1'b0;
        overrun     <= 1'b0;
      end else if (abort) begin
        timeout_err <= 1'b1;
      end else if (strobe) begin
        shift_reg <= word_next;
      end

      if (state == SELECT) begin
        bit_count <= '0;
      end else if (strobe && !complete) begin
        bit_count <= bit_count + 1'b1;
      end

      if (complete) begin
        sample_data  <= word_next;
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready) begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

  assign ATD_cs_n = (state == IDLE);
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_atd_rx_controller.sv
// Self-checking bench for atd_rx_controller (WORD_BITS=12, TIMEOUT_CYCLES=16).
module tb_atd_rx_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ATD_shift_enable;
  logic        ATD_data;
  logic        ATD_cs_n;
  logic        busy;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        timeout_err;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: what the consumer should currently see.
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_over;
  logic        m_terr;

  atd_rx_controller #(.WORD_BITS(12), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ATD_shift_enable(ATD_shift_enable),
    .ATD_data(ATD_data), .ATD_cs_n(ATD_cs_n), .busy(busy),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_data = 12'h000; m_valid = 1'b0; m_over = 1'b0; m_terr = 1'b0;
  endtask

  task automatic accept();
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    m_valid = 1'b0;
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL accept_valid got=%b exp=0", sample_valid); end
  endtask

  // One full capture; optional strobe in SELECT, start pulses in SHIFT/DONE, ready at completion.
  task automatic send_frame(input logic [11:0] w, input int gap, input bit sel_strobe,
                            input bit start_busy, input bit rdy_end, input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_over = 1'b0; m_terr = 1'b0;
    total++; if (ATD_cs_n !== 1'b0) begin bad++; $display("FAIL %s_sel_cs got=%b exp=0", tag, ATD_cs_n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_sel_busy got=%b exp=1", tag, busy); end
    if (sel_strobe) begin ATD_shift_enable = 1'b1; ATD_data = ~w[11]; end
    tick();
    ATD_shift_enable = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        start = start_busy;
        tick();
        start = 1'b0;
      end
      ATD_shift_enable = 1'b1;
      ATD_data = w[i];
      if (i == 0) sample_ready = rdy_end;
      tick();
      ATD_shift_enable = 1'b0;
      sample_ready = 1'b0;
    end
    m_over  = m_valid && !rdy_end;
    m_valid = 1'b1;
    m_data  = w;
    total++; if (sample_data !== m_data) begin bad++; $display("FAIL %s_data got=%h exp=%h", tag, sample_data, m_data); end
    total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b exp=1", tag, sample_valid); end
    total++; if (overrun !== m_over) begin bad++; $display("FAIL %s_overrun got=%b exp=%b", tag, overrun, m_over); end
    total++; if (ATD_cs_n !== 1'b0) begin bad++; $display("FAIL %s_done_cs got=%b exp=0", tag, ATD_cs_n); end
    start = start_busy;
    tick();
    start = 1'b0;
    total++; if (ATD_cs_n !== 1'b1) begin bad++; $display("FAIL %s_idle_cs got=%b exp=1", tag, ATD_cs_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle_busy got=%b exp=0", tag, busy); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL %s_terr got=%b exp=0", tag, timeout_err); end
  endtask

  task automatic test_reset();
    total++; if (ATD_cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs got=%b exp=1", ATD_cs_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (sample_data !== 12'h000) begin bad++; $display("FAIL rst_data got=%h exp=000", sample_data); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sample_valid); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_terr got=%b exp=0", timeout_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_basic();
    send_frame(12'hA5C, 3, 1'b0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_timeout();
    int n;
    accept();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ATD_shift_enable = 1'b1; ATD_data = 1'($urandom); tick();
    end
    ATD_shift_enable = 1'b0;
    n = 0;
    while (ATD_cs_n === 1'b0 && n < 100) begin tick(); n++; end
    m_terr = 1'b1;
    total++; if (n != 16) begin bad++; $display("FAIL to_cycles got=%0d exp=16", n); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_terr got=%b exp=1", timeout_err); end
    total++; if (sample_valid !== m_valid) begin bad++; $display("FAIL to_valid got=%b exp=%b", sample_valid, m_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b exp=0", busy); end
    start = 1'b1; tick(); start = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
    n = 0;
    while (ATD_cs_n === 1'b0 && n < 100) begin tick(); n++; end
    total++; if (n != 17) begin bad++; $display("FAIL to_silent got=%0d exp=17", n); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_terr2 got=%b exp=1", timeout_err); end
  endtask

  task automatic test_overrun();
    send_frame(12'h123, 1, 1'b0, 1'b0, 1'b0, "ovr_a");
    send_frame(12'hFFF, 1, 1'b0, 1'b0, 1'b0, "ovr_b");
    send_frame(12'h5A6, 0, 1'b0, 1'b0, 1'b1, "ovr_hs");
    accept();
  endtask

  task automatic test_ignored();
    logic [11:0] w;
    for (int i = 0; i < 4; i++) begin
      ATD_shift_enable = 1'b1; ATD_data = 1'b1; tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle got=%b exp=0", busy); end
    end
    ATD_shift_enable = 1'b0;
    w = 12'($urandom);
    send_frame(w, 2, 1'b1, 1'b1, 1'b0, "ign");
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_after got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) == 0 && m_valid) accept();
      send_frame(12'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 1'b0,
                 1'($urandom), "rand");
    end
  endtask

  task automatic test_reset_mid();
    send_frame(12'h3C3, 0, 1'b0, 1'b0, 1'b0, "pre");
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      ATD_shift_enable = 1'b1; ATD_data = 1'($urandom); tick();
      ATD_shift_enable = 1'b0; tick();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++; if (ATD_cs_n !== 1'b1) begin bad++; $display("FAIL mid_cs got=%b exp=1", ATD_cs_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", sample_valid); end
    total++; if (sample_data !== 12'h000) begin bad++; $display("FAIL mid_data got=%h exp=000", sample_data); end
    tick();
    rst = 1'b0;
    tick();
    send_frame(12'h0F0, 1, 1'b0, 1'b0, 1'b0, "post");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ATD_shift_enable = 1'b0; ATD_data = 1'b0; sample_ready = 1'b0;
    model_reset();
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_timeout();
    test_overrun();
    test_ignored();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
